// File: rtl/md_unit_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package md_unit_pkg;
  localparam int MD_XLEN  = 32;
  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = $clog2(MD_ITERS);
  localparam logic [MD_CNT_W-1:0] MD_LAST_ITER = MD_CNT_W'(MD_ITERS - 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } md_state_e;
endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if no borrow.
module md_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] trial, diff;

  assign trial = {rem_i, quo_i[W-1]};
  assign diff  = trial - {1'b0, dvs_i};
  // diff[W] is the borrow: the divisor did not fit this step
  assign rem_o = diff[W] ? trial[W-1:0] : diff[W-1:0];
  assign quo_o = {quo_i[W-2:0], ~diff[W]};
endmodule

// File: rtl/md_unit.sv
// Iterative HI/LO multiply/divide unit (32-step shift-add / restoring divide).
// Define MD_UNIT_FAST_MUL_EN to compute MULT/MULTU in a single cycle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       opb_q, opb_d, dvd_q, dvd_d;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                  neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;

  md_op_e          op_e;
  logic            sgn_op, is_div, s1, s2;
  logic [XLEN-1:0] m1, m2;

  assign op_e   = md_op_e'(op);
  assign sgn_op = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign is_div = (op_e == OP_DIV)  || (op_e == OP_DIVU);
  assign s1     = sgn_op & in1[XLEN-1];
  assign s2     = sgn_op & in2[XLEN-1];
  assign m1     = s1 ? -in1 : in1;
  assign m2     = s2 ? -in2 : in2;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, mul_res;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q & {XLEN{acc_q[0]}}};
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_res = neg_q ? -mul_nxt : mul_nxt;

  // Divide: acc = {remainder, dividend shifting into quotient}.
  logic [XLEN-1:0] rem_nxt, quo_nxt;
  md_div_step #(.W(XLEN)) u_div_step (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .quo_i (acc_q[XLEN-1:0]),
    .dvs_i (opb_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

`ifdef MD_UNIT_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
  assign fast_a = {{XLEN{s1}}, in1};
  assign fast_b = {{XLEN{s2}}, in2};
  assign fast_p = fast_a * fast_b;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    dvd_d   = dvd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          neg_d = s1 ^ s2;
          cnt_d = '0;
          if (is_div) begin
            state_d = ST_DIV;
            acc_d   = {{XLEN{1'b0}}, m1};
            opb_d   = m2;
            rneg_d  = s1;
            dvd_d   = in1;
          end else begin
`ifdef MD_UNIT_FAST_MUL_EN
            {hi_d, lo_d} = fast_p;
            done_d       = 1'b1;
`else
            state_d = ST_MUL;
            acc_d   = {{XLEN{1'b0}}, m2};
            opb_d   = m1;
`endif
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MD_LAST_ITER) begin
          {hi_d, lo_d} = mul_res;
          state_d      = ST_IDLE;
          done_d       = 1'b1;
        end
      end
      ST_DIV: begin
        acc_d = {rem_nxt, quo_nxt};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MD_LAST_ITER) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          // Zero divisor: all-ones quotient, original dividend as remainder
          if (opb_q == '0) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            hi_d = rneg_q ? -rem_nxt : rem_nxt;
            lo_d = neg_q  ? -quo_nxt : quo_nxt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      dvd_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      dvd_q   <= dvd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected {hi,lo,done cycle},
// a negedge monitor pops on done and checks HI/LO stay frozen while busy.
module tb_md_unit;
`ifdef MD_UNIT_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] in1, in2, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  md_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] mhi = '0, mlo = '0, hold_hi = '0, hold_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00: res = 64'(sa * sbv);
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          res = {32'(r), 32'(q)};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (busy === 1'b1) begin
        chk("hold_hi", {32'h0, hi}, {32'h0, hold_hi});
        chk("hold_lo", {32'h0, lo}, {32'h0, hold_lo});
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done=1 at cycle %0d, want no completion", cyc);
        end else begin
          e = sbq.pop_front();
          chk({e.nm, "_hi"},  {32'h0, hi}, {32'h0, e.hi});
          chk({e.nm, "_lo"},  {32'h0, lo}, {32'h0, e.lo});
          chk({e.nm, "_cyc"}, 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ex, input bit we_too, input string nm);
    int lat;
    exp_t x;
    wait_idle();
    lat   = (FAST && !o[1]) ? 0 : 32;
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    if (we_too) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = $urandom;
    end
    @(posedge clk);
    #1;
    hold_hi = mhi;
    hold_lo = mlo;
    x.hi = ex[63:32];
    x.lo = ex[31:0];
    x.cyc = cyc + lat;
    x.nm = nm;
    sbq.push_back(x);
    mhi = ex[63:32];
    mlo = ex[31:0];
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
    op  = 2'($urandom_range(0, 3));
    @(negedge clk);
    chk({nm, "_busy"}, {63'h0, busy}, {63'h0, (lat != 0)});
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] v);
    wait_idle();
    hi_we = to_hi;
    lo_we = !to_hi;
    wdata = v;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (to_hi) mhi = v; else mlo = v;
    @(negedge clk);
    chk("mt_hi", {32'h0, hi}, {32'h0, mhi});
    chk("mt_lo", {32'h0, lo}, {32'h0, mlo});
  endtask

  logic [1:0]  d_op [7] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10};
  logic [31:0] d_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd5,
                            32'h80000000, 32'd6, 32'hFFFFFFF9};
  logic [31:0] d_b  [7] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7, 32'd0};
  logic [63:0] d_ex [7] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB,
                            64'hFFFFFFFF_FFFFFFFD, 64'h00000005_FFFFFFFF,
                            64'h00000000_80000000, 64'h00000000_0000002A,
                            64'hFFFFFFF9_FFFFFFFF};

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want bench end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  o;
    int n;
    reset = 1'b0; start = 1'b0; op = '0; in1 = '0; in2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) issue(d_op[i], d_a[i], d_b[i], d_ex[i], 1'b0, $sformatf("dir%0d", i));

    mt_write(1'b1, 32'hCAFE0001);
    mt_write(1'b0, 32'h0BAD0002);

    // start and MT write in the same idle cycle: start wins
    issue(2'b11, 32'd1000, 32'd9, 64'h00000001_0000006F, 1'b1, "start_vs_we");

    // start and MTHI while busy are both dropped
    issue(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "busy_ignore");
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b00; in1 = 32'd5; in2 = 32'd5;
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 40)) - 32'd20; end
        2: begin a = $urandom; b = '0; end
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
      endcase
      issue(o, a, b, ref_md(o, a, b), (i % 7) == 3, $sformatf("rnd%0d", i));
    end

    // reset 10 cycles into a divide: abort, clear HI/LO, no done afterwards
    issue(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "rst_mid");
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    sbq.delete();
    mhi = '0; mlo = '0; hold_hi = '0; hold_lo = '0;
    chk("rstmid_busy", {63'h0, busy}, 64'h0);
    chk("rstmid_done", {63'h0, done}, 64'h0);
    chk("rstmid_hi", {32'h0, hi}, 64'h0);
    chk("rstmid_lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_hi", {32'h0, hi}, 64'h0);
    chk("post_rst_lo", {32'h0, lo}, 64'h0);
    chk("post_rst_busy", {63'h0, busy}, 64'h0);

    issue(2'b00, 32'd12345, 32'hFFFFFF00, ref_md(2'b00, 32'd12345, 32'hFFFFFF00), 1'b0, "after_rst");

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'h0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request strobe from EX stage, sampled on clk.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports in1, in2  input  32 each  rs/rt operands; in2 is the divisor.
REQ-007 SHALL have ports hi_we, lo_we, wdata  input  1/1/32  MTHI/MTLO write path.
REQ-008 SHALL have port busy  output  1  operation in flight; pipeline stalls MFHI/MFLO/MD ops on it.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-011 SHALL use states IDLE, MUL, DIV; IDLE->MUL on start with op[1]=0, IDLE->DIV on start with op[1]=1, MUL/DIV->IDLE after iteration 32.
REQ-012 SHALL capture operands and op on the accepting edge; later changes to in1/in2/op SHALL NOT affect the result.
REQ-013 SHALL multiply by 32-step shift-add on operand magnitudes; signed ops SHALL negate the 64-bit product when the operand signs differ.
REQ-014 SHALL divide by 32-step restoring division on magnitudes; signed quotient negative iff signs differ; remainder takes the dividend's sign.
REQ-015 SHALL, for start accepted at edge k, write {hi,lo} at edge k+32, hold busy=1 after edges k..k+31, and assert done=1 for exactly the cycle after edge k+32.
REQ-016 SHALL accept a new start in the cycle done=1, since state is IDLE then.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL produce, on divide by zero, lo=32'hFFFFFFFF and hi=dividend (DIVU) or hi=signed dividend (DIV), at normal latency.
REQ-019 SHALL produce lo=32'h80000000, hi=0 for DIV 32'h80000000 / 32'hFFFFFFFF.
REQ-020 SHALL apply hi_we/lo_we writes of wdata at the clock edge only when busy=0 and no start is accepted that edge; otherwise they are dropped.
REQ-021 SHALL let start take priority over simultaneous hi_we/lo_we in IDLE.
REQ-022 SHALL hold hi/lo stable while busy=1; intermediate products SHALL live in internal registers only.

Reset
REQ-023 SHALL, on reset low at any time including mid-operation, force state IDLE, busy=0, done=0, hi=0, lo=0, and iteration counter 0, aborting any operation.
REQ-024 SHALL leave the module idle after reset release with no spurious done.

Configuration
REQ-025 SHALL, with MD_UNIT_FAST_MUL_EN defined, compute MULT/MULTU in a single cycle: hi/lo written at the accepting edge, done=1 the next cycle, busy never asserted for multiply.
REQ-026 SHALL, without MD_UNIT_FAST_MUL_EN, use the 32-cycle iterative multiply of REQ-013/015; divide is iterative in both builds.

Structure
REQ-027 SHALL take op encodings, state encodings and the iteration count constant (32) from the shared pipeline package.
REQ-028 SHALL place the restoring-division datapath step in one sub-module, md_div_step, instantiated once.

Verification
REQ-029 SHALL cover MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done exactly 33 cycles after start cycle.
REQ-030 SHALL cover MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-031 SHALL cover DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 5 / 0 -> lo=32'hFFFFFFFF, hi=5.
REQ-032 SHALL cover start re-asserted and hi_we=1 wdata=32'h1234 while busy -> both ignored, result unchanged.
REQ-033 SHALL cover reset low 10 cycles into DIVU 100/7 -> busy=0, hi=lo=0 immediately, no done after release.
REQ-034 SHALL cover MD_UNIT_FAST_MUL_EN build: MULTU 6 x 7 -> lo=42, hi=0, done one cycle after start, busy stays 0.
